tt_um_davidparent_prbs31_chk: RTL and testbench

TT_UM_DAVIDPARENT_PRBS31_CHK -- requirements
Module: tt_um_davidparent_prbs31_chk

---
 rtl/tt_um_davidparent_prbs31_chk.sv | 147 ++++++++++++++
 tb/tb_tt_um_davidparent_prbs31_chk.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_davidparent_prbs31_chk.sv
// rtl/tt_um_davidparent_prbs31_chk.sv - PRBS31 (x^31+x^28+1) bit-serial checker with lock FSM and error counter
module tt_um_davidparent_prbs31_chk #(
  parameter int LOCK_LEN   = 64,
  parameter int UNLOCK_ERR = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int GW = $clog2(LOCK_LEN + 1);
  localparam int WW = $clog2(UNLOCK_ERR + 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t         r_state, w_state_nxt;
  logic [30:0]    r_sr, w_sr_nxt;
  logic [4:0]     r_fill, w_fill_nxt;
  logic [GW-1:0]  r_good, w_good_nxt;
  logic [6:0]     r_bit, w_bit_nxt;
  logic [WW-1:0]  r_win, w_win_nxt;
  logic [23:0]    r_err_cnt;
  logic           r_err_pulse;

  logic           w_d, w_valid, w_clr, w_p, w_err, w_sat;
  logic [30:0]    w_sr_d;
  logic [WW-1:0]  w_win_inc;
  logic           w_unused;

  assign w_d       = ui_in[0] ^ ui_in[3];
  assign w_valid   = ui_in[1];
  assign w_clr     = ui_in[2];
  assign w_p       = r_sr[27] ^ r_sr[30];
  assign w_sr_d    = {r_sr[29:0], w_d};
  assign w_err     = w_valid && (r_state == LOCKED) && (w_d != w_p);
  assign w_win_inc = r_win + WW'(w_err);
  assign w_sat     = (r_err_cnt == 24'hFFFFFF);
  assign w_unused  = &{1'b0, ena, uio_in, ui_in[7:6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_sr    <= '0;
      r_fill  <= '0;
      r_good  <= '0;
      r_bit   <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_fill  <= w_fill_nxt;
      r_good  <= w_good_nxt;
      r_bit   <= w_bit_nxt;
      r_win   <= w_win_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_fill_nxt  = r_fill;
    w_good_nxt  = r_good;
    w_bit_nxt   = r_bit;
    w_win_nxt   = r_win;
    if (w_valid) begin
      case (r_state)
        HUNT: begin
          w_sr_nxt = w_sr_d;
          if (r_fill == 5'd30) begin
            w_state_nxt = SYNC;
            w_fill_nxt  = '0;
            w_good_nxt  = '0;
          end else begin
            w_fill_nxt = r_fill + 5'd1;
          end
        end
        SYNC: begin
          w_sr_nxt = w_sr_d;
          if (w_d != w_p) begin
            w_good_nxt = '0;
          end else if (r_good == GW'(LOCK_LEN - 1)) begin
            // An all-zero register trivially predicts zeros; refuse to lock on it.
            w_good_nxt = '0;
            if (w_sr_d != 31'd0) begin
              w_state_nxt = LOCKED;
              w_bit_nxt   = '0;
              w_win_nxt   = '0;
            end
          end else begin
            w_good_nxt = r_good + GW'(1);
          end
        end
        LOCKED: begin
          w_sr_nxt = {r_sr[29:0], w_p};
          // The last bit of a window is judged before the window counters roll over.
          if (w_win_inc == WW'(UNLOCK_ERR)) begin
            w_state_nxt = HUNT;
            w_fill_nxt  = '0;
            w_good_nxt  = '0;
            w_bit_nxt   = '0;
            w_win_nxt   = '0;
          end else if (r_bit == 7'd127) begin
            w_bit_nxt = '0;
            w_win_nxt = '0;
          end else begin
            w_bit_nxt = r_bit + 7'd1;
            w_win_nxt = w_win_inc;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_err;
      if (w_clr) begin
        r_err_cnt <= '0;
      end else if (w_err && !w_sat) begin
        r_err_cnt <= r_err_cnt + 24'd1;
      end
    end
  end

  always_comb begin
    uio_out = 8'h00;
    case (ui_in[5:4])
      2'd0:    uio_out = r_err_cnt[7:0];
      2'd1:    uio_out = r_err_cnt[15:8];
      2'd2:    uio_out = r_err_cnt[23:16];
      default: uio_out = 8'h00;
    endcase
  end

  assign uo_out = {4'b0000, w_sat, (r_state == HUNT), r_err_pulse, (r_state == LOCKED)};
  assign uio_oe = 8'hFF;

endmodule

// File: tb/tb_tt_um_davidparent_prbs31_chk.sv
// tb/tb_tt_um_davidparent_prbs31_chk.sv - directed, table-driven bench for the PRBS31 checker
module tb_tt_um_davidparent_prbs31_chk;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;
  logic [30:0] g = 31'd1;
  int bsl = 0;

  always #5 clk = ~clk;

  tt_um_davidparent_prbs31_chk dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  typedef struct {
    logic [7:0] ui;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic gen_bit();
    logic b;
    b = g[27] ^ g[30];
    g = {g[29:0], b};
    return b;
  endfunction

  task automatic step(input logic d, input logic v, input logic clr, input logic inv, input logic [1:0] sel);
    ui_in = {2'b00, sel, inv, clr, v, d};
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic flip, input logic clr);
    step(gen_bit() ^ flip, 1'b1, clr, 1'b0, 2'd0);
    bsl++;
  endtask

  task automatic send_to_idx(input int idx);
    for (int i = 0; i < 256 && (bsl % 128) != idx; i++) send(1'b0, 1'b0);
  endtask

  task automatic read_cnt(output logic [23:0] c);
    ui_in = 8'h00; #1; c[7:0]   = uio_out;
    ui_in = 8'h10; #1; c[15:8]  = uio_out;
    ui_in = 8'h20; #1; c[23:16] = uio_out;
    ui_in = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic relock(input string tag);
    for (int n = 1; n <= 95; n++) begin
      send(1'b0, 1'b0);
      if (n == 94) chk({tag, "_not_locked_94"}, uo_out[0], 1'b0);
      if (n == 95) chk({tag, "_locked_95"}, uo_out[0], 1'b1);
    end
    bsl = 0;
  endtask

  initial begin
    vec_t vt[5];
    logic [23:0] cnt;
    int pulses;
    int lock_seen;

    // Reset state, observed before any clock edge
    #3;
    chk("rst_uo", uo_out, 8'h04);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hFF);
    do_reset();

    // Byte select with a known count (valid low, state HUNT)
    vt[0] = '{8'h00, 8'h04, 8'h56};
    vt[1] = '{8'h10, 8'h04, 8'h34};
    vt[2] = '{8'h20, 8'h04, 8'h12};
    vt[3] = '{8'h30, 8'h04, 8'h00};
    vt[4] = '{8'hD0, 8'h04, 8'h34};
    @(negedge clk);
    dut.r_err_cnt = 24'h123456;
    for (int i = 0; i < 5; i++) begin
      ui_in = vt[i].ui;
      #1;
      chk($sformatf("tbl%0d_uo", i), uo_out, vt[i].exp_uo);
      chk($sformatf("tbl%0d_uio", i), uio_out, vt[i].exp_uio);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    read_cnt(cnt);
    chk("clear_idle", cnt, 24'h0);
    chk("clear_keeps_hunt", uo_out, 8'h04);

    // Clean stream from seed 1, with valid-low gaps sprinkled in
    pulses = 0;
    for (int n = 1; n <= 10000; n++) begin
      send(1'b0, 1'b0);
      if (uo_out[1]) pulses++;
      if (n == 30) chk("hunt_at_30", uo_out[2], 1'b1);
      if (n == 31) chk("sync_at_31", uo_out[2], 1'b0);
      if (n == 94) chk("unlocked_94", uo_out[0], 1'b0);
      if (n == 95) begin
        chk("locked_95", uo_out[0], 1'b1);
        bsl = 0;
      end
      if (n % 13 == 0) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    chk("clean_no_pulse", pulses, 0);
    chk("clean_locked_end", uo_out[0], 1'b1);
    read_cnt(cnt);
    chk("clean_count", cnt, 24'h0);

    // Single flip at offset 500: flywheel absorbs it
    for (int n = 1; n < 500; n++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("flip_pulse", uo_out[1], 1'b1);
    chk("flip_locked", uo_out[0], 1'b1);
    chk("flip_sel0", uio_out, 8'h01);
    send(1'b0, 1'b0);
    chk("flip_pulse_one_cycle", uo_out[1], 1'b0);
    chk("flip_still_locked", uo_out[0], 1'b1);

    // Eight flips in one window force HUNT
    send(1'b0, 1'b1);
    send_to_idx(10);
    for (int k = 1; k <= 8; k++) begin
      send(1'b1, 1'b0);
      if (k == 7) chk("burst_7_locked", uo_out, 8'h03);
      if (k == 8) chk("burst_8_hunt", uo_out, 8'h06);
    end
    read_cnt(cnt);
    chk("burst_count", cnt, 24'd8);
    relock("burst_relock");

    // Window boundary: 7+1 split across windows stays locked; 7 then bit 127 unlocks
    send(1'b0, 1'b1);
    send_to_idx(100);
    for (int k = 0; k < 7; k++) send(1'b1, 1'b0);
    send_to_idx(0);
    send(1'b1, 1'b0);
    chk("win_split_locked", uo_out, 8'h03);
    send_to_idx(100);
    for (int k = 0; k < 6; k++) send(1'b1, 1'b0);
    send_to_idx(127);
    chk("win_pre127_locked", uo_out[0], 1'b1);
    send(1'b1, 1'b0);
    chk("win_127_hunt", uo_out, 8'h06);
    read_cnt(cnt);
    chk("win_count", cnt, 24'd15);
    relock("win_relock");

    // Saturation and clear-beats-increment
    dut.r_err_cnt = 24'hFFFFFD;
    send(1'b1, 1'b0);
    read_cnt(cnt);
    chk("sat_fffffe", cnt, 24'hFFFFFE);
    chk("sat_flag_low", uo_out[3], 1'b0);
    for (int k = 0; k < 3; k++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    read_cnt(cnt);
    chk("sat_ffffff", cnt, 24'hFFFFFF);
    chk("sat_flag", uo_out[3], 1'b1);
    send(1'b1, 1'b0);
    read_cnt(cnt);
    chk("sat_hold", cnt, 24'hFFFFFF);
    send(1'b1, 1'b1);
    read_cnt(cnt);
    chk("clr_with_err", cnt, 24'h0);
    chk("clr_flag_low", uo_out[3], 1'b0);
    chk("clr_keeps_lock", uo_out[0], 1'b1);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 50; k++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("pre_rst_sel0", uio_out, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_uo", uo_out, 8'h04);
    chk("async_rst_uio", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    relock("rst_relock");

    // All-zero input never locks and settles in SYNC
    do_reset();
    lock_seen = 0;
    for (int n = 0; n < 2000; n++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      if (uo_out[0]) lock_seen++;
    end
    chk("zeros_never_lock", lock_seen, 0);
    chk("zeros_in_sync", uo_out, 8'h00);

    // Inverted polarity stream with invert bit set
    do_reset();
    for (int n = 1; n <= 95; n++) begin
      step(~gen_bit(), 1'b1, 1'b0, 1'b1, 2'd0);
      if (n == 94) chk("inv_unlocked_94", uo_out[0], 1'b0);
      if (n == 95) chk("inv_locked_95", uo_out[0], 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
